// File: rtl/dcache_flush_unit_pkg.sv
// Shared data-cache configuration: geometry and derived widths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package dcache_flush_unit_pkg;

    localparam int unsigned DCACHE_NR_SETS = 256;
    localparam int unsigned DCACHE_NR_WAYS = 8;
    localparam int unsigned DCACHE_IDX_W   = $clog2(DCACHE_NR_SETS);
    localparam int unsigned DCACHE_WAY_W   = $clog2(DCACHE_NR_WAYS);

    // Counting direction for the zero counter
    typedef enum logic {
        LZC_TRAILING = 1'b0,
        LZC_LEADING  = 1'b1
    } lzc_mode_e;

endpackage

// File: rtl/dcache_flush_unit_lzc.sv
// Zero counter: trailing mode returns the index of the lowest set bit.
// Latency: combinational.
// Backpressure: none; an all-zero input yields 0.
module lzc
    import dcache_flush_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter lzc_mode_e   MODE  = LZC_TRAILING
) (
    input  logic [WIDTH-1:0]         in_i,
    output logic [$clog2(WIDTH)-1:0] cnt_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    // Last assignment wins: descending scan keeps the lowest set bit,
    // ascending scan keeps the highest set bit.
    always_comb begin
        cnt_o = '0;
        if (MODE == LZC_TRAILING) begin
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (in_i[i]) cnt_o = CNT_W'(i);
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (in_i[i]) cnt_o = CNT_W'(int'(WIDTH) - 1 - i);
            end
        end
    end

endmodule

// File: rtl/dcache_flush_unit.sv
// Whole-cache flush walker: per set read tags, write back dirty ways, invalidate.
// Latency: 3 cycles per clean set with free grants, +2 or more per dirty way.
// Backpressure: each request is held stable until its grant/ready arrives.
module dcache_flush_unit
    import dcache_flush_unit_pkg::*;
#(
    parameter int unsigned NR_SETS = DCACHE_NR_SETS,
    parameter int unsigned NR_WAYS = DCACHE_NR_WAYS,
    parameter int unsigned IDX_W   = $clog2(NR_SETS)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    output logic                       flush_ack_o,
    output logic                       busy_o,
    output logic                       tag_req_o,
    input  logic                       tag_gnt_i,
    output logic [IDX_W-1:0]           tag_idx_o,
    input  logic [NR_WAYS-1:0]         tag_valid_i,
    input  logic [NR_WAYS-1:0]         tag_dirty_i,
    output logic                       wb_valid_o,
    input  logic                       wb_ready_i,
    output logic [$clog2(NR_WAYS)-1:0] wb_way_o,
    input  logic                       wb_done_i,
    output logic                       inv_req_o,
    input  logic                       inv_gnt_i
);

    localparam int unsigned     WAY_W    = $clog2(NR_WAYS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_SETS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ_TAG,
        WAIT_TAG,
        WB_REQ,
        WB_WAIT,
        INVALIDATE,
        DONE,
        COOLDOWN
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [NR_WAYS-1:0] pending_q;
    logic [WAY_W-1:0]   low_way;
    logic [NR_WAYS-1:0] low_oh;

    // Lowest pending way; stable while pending_q is stable, so the
    // write-back way cannot move while a request is outstanding.
    lzc #(
        .WIDTH (NR_WAYS),
        .MODE  (LZC_TRAILING)
    ) i_lzc (
        .in_i  (pending_q),
        .cnt_o (low_way)
    );

    assign low_oh = NR_WAYS'(1) << low_way;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; flush_i is only looked at in IDLE, so a falling
    // request mid-walk and the stale request during COOLDOWN are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (flush_i) state_d = READ_TAG;
            READ_TAG:   if (tag_gnt_i) state_d = WAIT_TAG;
            WAIT_TAG:   state_d = |(tag_valid_i & tag_dirty_i) ? WB_REQ : INVALIDATE;
            WB_REQ:     if (wb_ready_i) state_d = WB_WAIT;
            WB_WAIT: begin
                if (wb_done_i) begin
                    state_d = |(pending_q & ~low_oh) ? WB_REQ : INVALIDATE;
                end
            end
            INVALIDATE: begin
                if (inv_gnt_i) state_d = (idx_q == LAST_IDX) ? DONE : READ_TAG;
            end
            DONE:       state_d = COOLDOWN;
            COOLDOWN:   state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // Set index and pending write-back mask; the index is compared
    // against the last set before incrementing, so it never wraps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q     <= '0;
            pending_q <= '0;
        end else begin
            case (state_q)
                IDLE:       if (flush_i) idx_q <= '0;
                WAIT_TAG:   pending_q <= tag_valid_i & tag_dirty_i;
                WB_WAIT:    if (wb_done_i) pending_q <= pending_q & ~low_oh;
                INVALIDATE: if (inv_gnt_i && idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
                DONE:       idx_q <= '0;
                default:    ;
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        busy_o      = (state_q != IDLE);
        tag_req_o   = (state_q == READ_TAG);
        wb_valid_o  = (state_q == WB_REQ);
        wb_way_o    = (state_q == WB_REQ) ? low_way : '0;
        inv_req_o   = (state_q == INVALIDATE);
        flush_ack_o = (state_q == DONE);
        tag_idx_o   = idx_q;
    end

endmodule

// File: tb/tb_dcache_flush_unit.sv
// Self-checking bench for dcache_flush_unit with 4 sets x 2 ways.
// Latency: n/a.
// Backpressure: bench stalls tag grant and write-back ready per vector.
module tb_dcache_flush_unit;

    localparam int NS = 4;
    localparam int NW = 2;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       flush_i;
    logic       flush_ack_o;
    logic       busy_o;
    logic       tag_req_o;
    logic       tag_gnt_i;
    logic [1:0] tag_idx_o;
    logic [1:0] tag_valid_i;
    logic [1:0] tag_dirty_i;
    logic       wb_valid_o;
    logic       wb_ready_i;
    logic [0:0] wb_way_o;
    logic       wb_done_i;
    logic       inv_req_o;
    logic       inv_gnt_i;

    always #5 clk = ~clk;

    dcache_flush_unit #(
        .NR_SETS (NS),
        .NR_WAYS (NW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .flush_ack_o (flush_ack_o),
        .busy_o      (busy_o),
        .tag_req_o   (tag_req_o),
        .tag_gnt_i   (tag_gnt_i),
        .tag_idx_o   (tag_idx_o),
        .tag_valid_i (tag_valid_i),
        .tag_dirty_i (tag_dirty_i),
        .wb_valid_o  (wb_valid_o),
        .wb_ready_i  (wb_ready_i),
        .wb_way_o    (wb_way_o),
        .wb_done_i   (wb_done_i),
        .inv_req_o   (inv_req_o),
        .inv_gnt_i   (inv_gnt_i)
    );

    typedef struct packed {
        logic       is_wb;
        logic [1:0] idx;
        logic [0:0] way;
    } ev_t;

    // One walk: cache contents (2 bits per set), stalls, expected results
    typedef struct {
        logic [7:0] vld;
        logic [7:0] dty;
        int         rstall;   // wb_ready_i low cycles per request
        int         dly;      // extra WB_WAIT cycles before wb_done_i
        int         gset;     // set whose tag grant is stalled (-1 none)
        int         gn;       // grant stall cycles
        bit         noise;    // wb_done_i high whenever no write-back is in flight
        bit         drop;     // flush_i falls mid-walk
        int         exp_wb;
        int         exp_lat;
    } vec_t;

    vec_t vecs[6];
    ev_t  exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [7:0] cur_vld, cur_dty;
    int   cur_rstall, cur_dly, cur_gset, cur_gn;
    bit   cur_noise;
    int   gst_cnt, rs_cnt, done_cnt, outstanding, wb_cnt;
    int   start_cyc, ack_cyc;
    bit   wb_act, busy_prev, hs_idx1;
    logic [0:0] wb_way_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_pop(input string name, input ev_t got);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected event %0h, scoreboard empty", name, got);
        end else begin
            e = exp_q.pop_front();
            chk(name, 32'(got), 32'(e));
        end
    endtask

    // One clock: drive responder inputs at the falling edge, then monitor
    task automatic step();
        @(negedge clk);
        cyc++;
        tag_valid_i = cur_vld[2*int'(tag_idx_o) +: 2];
        tag_dirty_i = cur_dty[2*int'(tag_idx_o) +: 2];
        if (tag_req_o && int'(tag_idx_o) == cur_gset && gst_cnt < cur_gn) begin
            tag_gnt_i = 1'b0;
            gst_cnt++;
        end else begin
            tag_gnt_i = 1'b1;
        end
        wb_done_i = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) wb_done_i = 1'b1;
        end else if (cur_noise) begin
            wb_done_i = 1'b1;
        end
        if (wb_valid_o) begin
            if (!wb_act) begin
                wb_act      = 1'b1;
                wb_way_seen = wb_way_o;
            end else begin
                chk("wb_way_hold", 32'(wb_way_o), 32'(wb_way_seen));
            end
            if (rs_cnt < cur_rstall) begin
                wb_ready_i = 1'b0;
                rs_cnt++;
            end else begin
                wb_ready_i = 1'b1;
            end
        end else begin
            wb_ready_i = 1'b1;
        end
        if (wb_done_i && outstanding > 0) outstanding--;
        if (wb_valid_o && wb_ready_i) begin
            sb_pop("sb_wb", ev_t'{is_wb: 1'b1, idx: tag_idx_o, way: wb_way_o});
            if (tag_idx_o == 2'd1) hs_idx1 = 1'b1;
            wb_cnt++;
            outstanding++;
            wb_act   = 1'b0;
            rs_cnt   = 0;
            done_cnt = cur_dly + 1;
        end
        if (inv_req_o && inv_gnt_i) begin
            chk("inv_after_done", 32'(outstanding), 32'd0);
            sb_pop("sb_inv", ev_t'{is_wb: 1'b0, idx: tag_idx_o, way: 1'b0});
        end
        if (busy_o && !busy_prev) start_cyc = cyc;
        if (flush_ack_o) ack_cyc = cyc;
        busy_prev = busy_o;
    endtask

    task automatic run_walk(input vec_t v, input int vn);
        bit got;
        cur_vld = v.vld;     cur_dty = v.dty;
        cur_rstall = v.rstall; cur_dly = v.dly;
        cur_gset = v.gset;   cur_gn = v.gn;
        cur_noise = v.noise;
        gst_cnt = 0; rs_cnt = 0; done_cnt = 0; outstanding = 0; wb_cnt = 0;
        wb_act = 1'b0; ack_cyc = -1; start_cyc = -1;
        for (int s = 0; s < NS; s++) begin
            logic [1:0] p;
            p = v.vld[2*s +: 2] & v.dty[2*s +: 2];
            for (int w = 0; w < NW; w++) begin
                if (p[w]) exp_q.push_back(ev_t'{is_wb: 1'b1, idx: 2'(s), way: 1'(w)});
            end
            exp_q.push_back(ev_t'{is_wb: 1'b0, idx: 2'(s), way: 1'b0});
        end
        flush_i = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 600 && !got; k++) begin
            step();
            if (flush_ack_o) got = 1'b1;
            if (v.drop && k == 3) flush_i = 1'b0;
        end
        chk($sformatf("v%0d_ack_seen", vn), 32'(got), 32'd1);
        if (got) begin
            chk($sformatf("v%0d_latency", vn), 32'(ack_cyc - start_cyc), 32'(v.exp_lat));
            chk($sformatf("v%0d_wb_count", vn), 32'(wb_cnt), 32'(v.exp_wb));
            chk($sformatf("v%0d_sb_left", vn), 32'(exp_q.size()), 32'd0);
            // COOLDOWN: flush_i may still be high and must be ignored
            step();
            chk($sformatf("v%0d_cool_busy", vn), 32'(busy_o), 32'd1);
            chk($sformatf("v%0d_ack_1cyc", vn), 32'(flush_ack_o), 32'd0);
            step();
            chk($sformatf("v%0d_idle_busy", vn), 32'(busy_o), 32'd0);
            flush_i = 1'b0;
            step();
            chk($sformatf("v%0d_no_rewalk", vn), 32'({busy_o, tag_req_o}), 32'd0);
        end
        flush_i = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        // vld/dty bit 2s+w is set s way w
        vecs[0] = '{8'h00, 8'h00, 0, 0, -1, 0, 1'b1, 1'b0, 0, 12};
        vecs[1] = '{8'b0011_0000, 8'b0010_0000, 0, 0, -1, 0, 1'b0, 1'b0, 1, 14};
        vecs[2] = '{8'b0000_1100, 8'b0000_1100, 3, 0, -1, 0, 1'b0, 1'b0, 2, 22};
        vecs[3] = '{8'h00, 8'h00, 0, 0, 3, 5, 1'b1, 1'b0, 0, 17};
        vecs[4] = '{8'hFF, 8'b1001_0011, 1, 2, -1, 0, 1'b0, 1'b1, 4, 32};
        vecs[5] = '{8'b0100_0000, 8'b1111_0000, 0, 3, -1, 0, 1'b0, 1'b0, 1, 17};

        rst_ni = 1'b0; flush_i = 1'b0;
        tag_gnt_i = 1'b1; tag_valid_i = '0; tag_dirty_i = '0;
        wb_ready_i = 1'b1; wb_done_i = 1'b0; inv_gnt_i = 1'b1;
        cur_vld = '0; cur_dty = '0; cur_rstall = 0; cur_dly = 0;
        cur_gset = -1; cur_gn = 0; cur_noise = 1'b0;
        gst_cnt = 0; rs_cnt = 0; done_cnt = 0; outstanding = 0; wb_cnt = 0;
        wb_act = 1'b0; busy_prev = 1'b0; hs_idx1 = 1'b0; wb_way_seen = '0;
        start_cyc = -1; ack_cyc = -1;

        step(); step();
        chk("rst_ctrl_outs", 32'({flush_ack_o, busy_o, tag_req_o, wb_valid_o, inv_req_o}), 32'd0);
        chk("rst_tag_idx", 32'(tag_idx_o), 32'd0);
        chk("rst_wb_way", 32'(wb_way_o), 32'd0);
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_walk(vecs[i], i);

        // Reset while waiting for write-back completion of set 1
        cur_vld = 8'b0000_0100; cur_dty = 8'b0000_0100;
        cur_rstall = 0; cur_dly = 20; cur_gset = -1; cur_gn = 0; cur_noise = 1'b0;
        wb_cnt = 0; hs_idx1 = 1'b0;
        exp_q.push_back(ev_t'{is_wb: 1'b0, idx: 2'd0, way: 1'b0});
        exp_q.push_back(ev_t'{is_wb: 1'b1, idx: 2'd1, way: 1'b0});
        flush_i = 1'b1;
        for (int k = 0; k < 100 && !hs_idx1; k++) step();
        chk("mid_hs_set1", 32'(hs_idx1), 32'd1);
        step();
        chk("mid_busy_before", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        flush_i = 1'b0;
        #1;
        chk("mid_rst_outs", 32'({flush_ack_o, busy_o, tag_req_o, wb_valid_o, inv_req_o}), 32'd0);
        chk("mid_rst_idx_way", 32'({tag_idx_o, wb_way_o}), 32'd0);
        exp_q.delete();
        outstanding = 0; done_cnt = 0; wb_act = 1'b0; rs_cnt = 0;
        step(); step();
        chk("mid_no_ack", 32'(flush_ack_o), 32'd0);
        rst_ni = 1'b1;
        step();
        run_walk(vecs[0], 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
